// File: rtl/hsm_host_link_if.sv
// Host link bundle: session control, device UART/power pins, and the
// valid/ready byte streams toward host logic. The link endpoint uses the
// slave view; whoever drives the device pins and byte streams uses master.
interface hsm_host_link_if;
  logic       session_en;
  logic       session_active;
  logic       wake_fail;
  logic       dev_rx;
  logic       dev_cts;
  logic       dev_tx;
  logic       dev_rts;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_frame_err;

  modport slave (
    input  session_en, dev_tx, dev_rts, tx_data, tx_valid, rx_ready,
    output session_active, wake_fail, dev_rx, dev_cts, tx_ready,
           rx_data, rx_valid, rx_overrun, rx_frame_err
  );

  modport master (
    output session_en, dev_tx, dev_rts, tx_data, tx_valid, rx_ready,
    input  session_active, wake_fail, dev_rx, dev_cts, tx_ready,
           rx_data, rx_valid, rx_overrun, rx_frame_err
  );
endinterface

// File: rtl/hsm_host_link.sv
// Host-side endpoint of the HSM UART/power link: wakes the device via cts,
// waits for rts, then runs a flow-controlled 8N1 byte link in both directions.
module hsm_host_link #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WAKE_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            resetn,
  hsm_host_link_if.slave  link
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int WW = $clog2(WAKE_TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAKE, S_ACTIVE, S_DRAIN} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_WAITHI} rx_st_t;

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  state_t          state_q;
  logic [WW-1:0]   wake_cnt_q;
  logic            dev_cts_q, session_active_q, wake_fail_q;

  logic            tx_s1_q, tx_s2_q, tx_s3_q;
  logic            rts_s1_q, rts_s2_q;
  logic            rxd, rxd_fall;

  logic            tx_busy_q;
  logic [8:0]      tx_shift_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic            dev_rx_q;
  logic            tx_ready, tx_accept;

  rx_st_t          rx_st_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [3:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            rx_en, rx_idle, stop_ok, stop_bad;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_ovr_q, rx_ovr_d;
  logic            rx_fe_q, rx_fe_d;

  // ---------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------
  // Two-flop sync on both device inputs; tx gets a third flop for edge detect
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_s1_q  <= 1'b1;
      tx_s2_q  <= 1'b1;
      tx_s3_q  <= 1'b1;
      rts_s1_q <= 1'b1;
      rts_s2_q <= 1'b1;
    end else begin
      tx_s1_q  <= link.dev_tx;
      tx_s2_q  <= tx_s1_q;
      tx_s3_q  <= tx_s2_q;
      rts_s1_q <= link.dev_rts;
      rts_s2_q <= rts_s1_q;
    end
  end

  assign rxd      = tx_s2_q;
  assign rxd_fall = tx_s3_q & ~tx_s2_q;

  // ---------------------------------------------------------------------
  // Session FSM
  // ---------------------------------------------------------------------
  // cts is registered from the next state so it tracks the state change
  // on the same edge; in ACTIVE/DRAIN it mirrors the next holding-reg state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      wake_cnt_q       <= '0;
      dev_cts_q        <= 1'b1;
      session_active_q <= 1'b0;
      wake_fail_q      <= 1'b0;
    end else begin
      wake_fail_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          dev_cts_q        <= 1'b1;
          session_active_q <= 1'b0;
          if (link.session_en) begin
            state_q    <= S_WAKE;
            wake_cnt_q <= '0;
            dev_cts_q  <= 1'b0;
          end
        end
        S_WAKE: begin
          // Device readiness beats both cancel and timeout
          if (!rts_s2_q) begin
            state_q          <= S_ACTIVE;
            session_active_q <= 1'b1;
            dev_cts_q        <= rx_valid_d;
          end else if (!link.session_en) begin
            state_q   <= S_IDLE;
            dev_cts_q <= 1'b1;
          end else if (wake_cnt_q == WAKE_LAST) begin
            state_q     <= S_IDLE;
            dev_cts_q   <= 1'b1;
            wake_fail_q <= 1'b1;
          end else begin
            wake_cnt_q <= wake_cnt_q + 1'b1;
          end
        end
        S_ACTIVE: begin
          dev_cts_q <= rx_valid_d;
          if (!link.session_en) begin
            state_q          <= S_DRAIN;
            session_active_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          dev_cts_q <= rx_valid_d;
          if (!tx_busy_q && rx_idle) begin
            state_q   <= S_IDLE;
            dev_cts_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          dev_cts_q <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  // rts only gates the start of a frame; a frame in flight always completes
  assign tx_ready  = (state_q == S_ACTIVE) && !tx_busy_q && !rts_s2_q;
  assign tx_accept = link.tx_valid && tx_ready;

  // Shift out start, 8 data bits LSB first, stop; each held CLKS_PER_BIT cycles
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      dev_rx_q   <= 1'b1;
    end else if (tx_accept) begin
      tx_busy_q  <= 1'b1;
      tx_shift_q <= {1'b1, link.tx_data};
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      dev_rx_q   <= 1'b0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          dev_rx_q  <= 1'b1;
        end else begin
          tx_bit_q   <= tx_bit_q + 1'b1;
          dev_rx_q   <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  assign rx_en    = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
  // Waiting for the line to recover after a framing error is not a frame
  assign rx_idle  = (rx_st_q == R_IDLE) || (rx_st_q == R_WAITHI);
  assign stop_ok  = (rx_st_q == R_DATA) && (rx_cnt_q == BIT_LAST) &&
                    (rx_bit_q == 4'd8) && rxd;
  assign stop_bad = (rx_st_q == R_DATA) && (rx_cnt_q == BIT_LAST) &&
                    (rx_bit_q == 4'd8) && !rxd;

  // Frame sampler: mid-start check, then one sample per bit period
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else if (!rx_en) begin
      rx_st_q  <= R_IDLE;
      rx_cnt_q <= '0;
    end else begin
      case (rx_st_q)
        R_IDLE: begin
          if (rxd_fall) begin
            rx_st_q  <= R_START;
            rx_cnt_q <= '0;
          end
        end
        R_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rxd ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_bit_q == 4'd8) begin
              rx_st_q <= rxd ? R_IDLE : R_WAITHI;
            end else begin
              rx_shift_q <= {rxd, rx_shift_q[7:1]};
              rx_bit_q   <= rx_bit_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_WAITHI: begin
          if (rxd) rx_st_q <= R_IDLE;
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  // Holding register: a consume on the same cycle frees space for the new byte
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_ovr_d   = 1'b0;
    rx_fe_d    = 1'b0;
    if (rx_valid_q && link.rx_ready) rx_valid_d = 1'b0;
    if (stop_ok) begin
      if (rx_valid_d) begin
        rx_ovr_d = 1'b1;
      end else begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_shift_q;
      end
    end
    if (stop_bad) rx_fe_d = 1'b1;
  end

  // Holding register and error pulse flops
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_ovr_q   <= 1'b0;
      rx_fe_q    <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_fe_q    <= rx_fe_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign link.session_active = session_active_q;
  assign link.wake_fail      = wake_fail_q;
  assign link.dev_rx         = dev_rx_q;
  assign link.dev_cts        = dev_cts_q;
  assign link.tx_ready       = tx_ready;
  assign link.rx_data        = rx_data_q;
  assign link.rx_valid       = rx_valid_q;
  assign link.rx_overrun     = rx_ovr_q;
  assign link.rx_frame_err   = rx_fe_q;

endmodule

// File: doc/hsm_host_link.md
Name: hsm_host_link

Overview:
Host-side endpoint of the HSM's UART/power link. It drives the device's uart_rx and uart_cts and observes the device's uart_tx and uart_rts. It wakes the device by pulling cts low and confirms the device is running once rts goes low. It then runs a flow-controlled 8N1 byte link with valid/ready byte interfaces toward host logic. It sits in test harnesses and host FPGA designs facing the HSM SoC wrapper.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; must be ≥4 and even.
WAKE_TIMEOUT, 1024, cycles allowed in WAKE for synced dev_rts to go low.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
session_en  in  1  host requests a device session
session_active  out  1  high in ACTIVE
wake_fail  out  1  1-cycle pulse on wake timeout
dev_rx  out  1  to device uart_rx; idle 1
dev_cts  out  1  to device uart_cts; active-low: wake request and host-ready-to-receive
dev_tx  in  1  from device uart_tx
dev_rts  in  1  from device uart_rts; low means device ready to receive
tx_data  in  8  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  byte accepted on tx_valid&&tx_ready
rx_data  out  8  received byte
rx_valid  out  1  rx_data holding register full
rx_ready  in  1  holding register consumed on rx_valid&&rx_ready
rx_overrun  out  1  1-cycle pulse: completed byte dropped because holding register full
rx_frame_err  out  1  1-cycle pulse: stop bit sampled 0

Behaviour:
- Reset (resetn low at posedge): state IDLE, dev_rx=1, dev_cts=1, tx_ready=0, rx_valid=0, rx_data=0, all pulses 0, synchronizers=1, counters 0. Applies mid-frame: any in-flight frame is abandoned, and dev_rx is 1 the cycle after.
- dev_tx and dev_rts each pass through a 2-flop synchronizer (reset 1). All decisions use synced values.
- Session FSM:
  - IDLE: dev_cts=1. session_en=1 → WAKE, wake counter cleared.
  - WAKE: dev_cts=0. Synced rts=0 → ACTIVE. session_en=0 → IDLE. Counter reaches WAKE_TIMEOUT-1 → wake_fail pulse, IDLE. Once back in IDLE, a still-high session_en re-enters WAKE on the next cycle.
  - ACTIVE: session_active=1. dev_cts = rx_valid, i.e. high while the holding register is full. session_en=0 → DRAIN.
  - DRAIN: dev_cts=rx_valid. No new TX accepted. When TX is idle and RX is idle (no frame in progress) → IDLE.
- TX:
  - tx_ready=1 iff state ACTIVE, transmitter idle, synced rts=0.
  - On acceptance tx_ready drops the next cycle. dev_rx drives start bit 0 from the next cycle, then data bits LSB first, then stop bit 1, each CLKS_PER_BIT cycles (10*CLKS_PER_BIT total).
  - tx_ready may reassert the cycle after the stop bit ends.
  - rts is checked only before the start bit; rts rising mid-frame does not abort the frame.
- RX:
  - Enabled in ACTIVE and DRAIN.
  - Falling edge of synced dev_tx starts a frame. After CLKS_PER_BIT/2 cycles the line is re-sampled; if it is 1, this is a false start and RX returns to idle.
  - Data bits are sampled every CLKS_PER_BIT thereafter, LSB first, followed by the stop sample.
  - Stop=1 with holding register empty: rx_data loaded, rx_valid=1 next cycle.
  - Stop=1 with holding register full: rx_overrun pulse, byte dropped, rx_data unchanged.
  - Stop=0: rx_frame_err pulse, byte discarded. RX then waits for the line to return to 1 before re-arming.
  - If rx_ready coincides with a completing byte, the consume happens first: the new byte is loaded and there is no overrun.
  - rx_valid and rx_data persist across IDLE until consumed.
- Simultaneous events:
  - session_en falling the same cycle as a TX acceptance: the byte is sent in DRAIN.
  - Wake timeout and rts=0 in the same cycle: rts wins, state goes to ACTIVE.

Test Plan:
- Reset, session_en=1, dev_rts=1 → dev_cts=0 within 1 cycle. Drop dev_rts at cycle 10 → session_active=1 by cycle 13 (sync plus FSM delay).
- WAKE_TIMEOUT=64, dev_rts held 1 → wake_fail pulses once at cycle 64 of WAKE, dev_cts=1 the next cycle, then WAKE re-entered.
- ACTIVE, CLKS_PER_BIT=16, send 0xA5 → dev_rx sequence 0,1,0,1,0,0,1,0,1,1, each 16 cycles. tx_ready low for 160 cycles.
- Hold dev_rts=1 in ACTIVE with tx_valid=1 → tx_ready stays 0 and dev_rx stays 1. Release dev_rts → byte starts within 4 cycles.
- Drive 0x3C on dev_tx → rx_valid with rx_data=0x3C and dev_cts=1. Send 0x55 without rx_ready → rx_overrun pulses, rx_data stays 0x3C. Assert rx_ready → dev_cts=0.
- Frame with stop bit 0 → rx_frame_err pulses, rx_valid stays 0. A 4-cycle low glitch → no byte and no error.
